drum_mac_pipe: RTL and testbench



---
 rtl/drum_mac_pipe.sv | 169 ++++++++++++++++
 tb/tb_drum_mac_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/drum_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : drum_mac_pipe
// Function : Three-stage DRUM approximate multiplier with wrapping accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module drum_mac_pipe #(
  parameter int N     = 8,
  parameter int M     = 8,
  parameter int K     = 3,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [M-1:0]     in_b,
  input  logic             in_signed,
  input  logic             in_exact,
  input  logic             in_acc,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N+M-1:0]   out_prod,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);
  localparam int P  = N + M;
  localparam int W  = (N > M) ? N : M;
  localparam int SW = $clog2(P + 1);

  function automatic logic [SW-1:0] lead_one(input logic [W-1:0] x);
    logic [SW-1:0] t;
    t = '0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) t = SW'(i);
    end
    return t;
  endfunction

  // Keep the leading one plus K-2 bits below it; the forced LSB is the unbiasing term
  function automatic logic [K+SW-1:0] drum_reduce(input logic [W-1:0] x);
    logic [SW-1:0]   t;
    logic [SW-1:0]   sh;
    logic [K+SW-1:0] r;
    t = lead_one(x);
    if (t >= SW'(K)) begin
      sh = t - SW'(K - 1);
      r  = {K'(x >> sh) | {{(K-1){1'b0}}, 1'b1}, sh};
    end else begin
      r  = {x[K-1:0], {SW{1'b0}}};
    end
    return r;
  endfunction

  logic adv;
  logic out_valid_q;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;

  // Stage 1: magnitude and reduction
  logic [N-1:0]    mag_a;
  logic [M-1:0]    mag_b;
  logic [K+SW-1:0] red_a;
  logic [K+SW-1:0] red_b;

  always_comb begin
    mag_a = (in_signed && in_a[N-1]) ? ~in_a : in_a;
    mag_b = (in_signed && in_b[M-1]) ? ~in_b : in_b;
    red_a = drum_reduce(W'(mag_a));
    red_b = drum_reduce(W'(mag_b));
  end

  logic          v1_q, sgn1_q, sig1_q, ex1_q, acc1_q, clr1_q;
  logic [K-1:0]  ak1_q, bk1_q;
  logic [SW-1:0] sha1_q, shb1_q;
  logic [N-1:0]  ma1_q;
  logic [M-1:0]  mb1_q;

  logic           v2_q, sgn2_q, sig2_q, ex2_q, acc2_q, clr2_q;
  logic [2*K-1:0] kk2_q;
  logic [SW-1:0]  sh2_q;
  logic [P-1:0]   exp2_q;

  logic [P-1:0]     prod_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;

  // Stage 3: shift, sign restore, accumulate
  logic [P-1:0]     p_w;
  logic [P-1:0]     prod_d;
  logic [ACC_W-1:0] ext_w;
  logic [ACC_W-1:0] sum_w;
  logic [ACC_W-1:0] acc_d;
  logic             ovf_d;

  always_comb begin
    p_w    = ex2_q ? exp2_q : (P'(kk2_q) << sh2_q);
    prod_d = sgn2_q ? ~p_w : p_w;
    ext_w  = sig2_q ? ACC_W'($signed(prod_d)) : ACC_W'(prod_d);
    sum_w  = acc_q + ext_w;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    if (acc2_q) begin
      if (clr2_q) begin
        acc_d = ext_w;
      end else begin
        acc_d = sum_w;
        if ((acc_q[ACC_W-1] == ext_w[ACC_W-1]) && (sum_w[ACC_W-1] != acc_q[ACC_W-1]))
          ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0; sgn1_q <= 1'b0; sig1_q <= 1'b0; ex1_q <= 1'b0;
      acc1_q <= 1'b0; clr1_q <= 1'b0;
      ak1_q <= '0; bk1_q <= '0; sha1_q <= '0; shb1_q <= '0;
      ma1_q <= '0; mb1_q <= '0;
      v2_q <= 1'b0; sgn2_q <= 1'b0; sig2_q <= 1'b0; ex2_q <= 1'b0;
      acc2_q <= 1'b0; clr2_q <= 1'b0;
      kk2_q <= '0; sh2_q <= '0; exp2_q <= '0;
      out_valid_q <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      v1_q   <= in_valid;
      sgn1_q <= in_signed & (in_a[N-1] ^ in_b[M-1]);
      sig1_q <= in_signed;
      ex1_q  <= in_exact;
      acc1_q <= in_acc;
      clr1_q <= in_clr;
      ak1_q  <= red_a[K+SW-1:SW];
      bk1_q  <= red_b[K+SW-1:SW];
      sha1_q <= red_a[SW-1:0];
      shb1_q <= red_b[SW-1:0];
      ma1_q  <= mag_a;
      mb1_q  <= mag_b;

      v2_q   <= v1_q;
      sgn2_q <= sgn1_q;
      sig2_q <= sig1_q;
      ex2_q  <= ex1_q;
      acc2_q <= acc1_q;
      clr2_q <= clr1_q;
      kk2_q  <= (2*K)'(ak1_q) * (2*K)'(bk1_q);
      sh2_q  <= sha1_q + shb1_q;
      exp2_q <= P'(ma1_q) * P'(mb1_q);

      out_valid_q <= v2_q;
      if (v2_q) begin
        prod_q <= prod_d;
        acc_q  <= acc_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_prod = prod_q;
  assign out_acc  = acc_q;
  assign out_ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_drum_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_drum_mac_pipe
// Function : Scoreboard bench for drum_mac_pipe with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drum_mac_pipe;
  localparam int N = 8, M = 8, K = 3, ACC_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [N-1:0]     in_a;
  logic [M-1:0]     in_b;
  logic             in_signed, in_exact, in_acc, in_clr;
  logic             out_valid, out_ready;
  logic [N+M-1:0]   out_prod;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;

  drum_mac_pipe #(.N(N), .M(M), .K(K), .ACC_W(ACC_W)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_exact(in_exact), .in_acc(in_acc), .in_clr(in_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_acc(out_acc), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] prod;
    logic [15:0] acc;
    logic        ovf;
    int          xfer;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pop one expectation per output transfer
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_output: got prod 0x%0h with empty scoreboard, required none", out_prod);
      end else begin
        mon_e = sb.pop_front();
        chk("out_prod", 32'(out_prod), 32'(mon_e.prod));
        chk("out_acc",  32'(out_acc),  32'(mon_e.acc));
        chk("out_ovf",  32'(out_ovf),  32'(mon_e.ovf));
        if (mon_e.chk_lat) chk("latency", 32'(cyc - mon_e.xfer + 1), 32'd3);
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input bit s, input bit e, input bit ac, input bit cl,
                      input logic [15:0] ep, input logic [15:0] ea, input bit eo,
                      input bit lat);
    int   guard;
    exp_t x;
    in_a = a; in_b = b; in_signed = s; in_exact = e; in_acc = ac; in_clr = cl;
    in_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: in_ready 0 after %0d cycles, required 1", guard);
      in_valid = 1'b0;
    end else begin
      x.prod = ep; x.acc = ea; x.ovf = eo; x.xfer = cyc + 1; x.chk_lat = lat;
      sb.push_back(x);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Flip the mode bits so later stages cannot borrow them from the inputs
      in_signed = ~s; in_exact = ~e; in_acc = ~ac; in_clr = ~cl;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || out_valid) && g < 60) begin
      @(posedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_signed = 1'b0; in_exact = 1'b0; in_acc = 1'b0; in_clr = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_prod",  32'(out_prod),  32'd0);
    chk("reset_out_acc",   32'(out_acc),   32'd0);
    chk("reset_out_ovf",   32'(out_ovf),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    //    a      b     s  e  ac cl  prod       acc       ovf lat
    send(8'd5,   8'd3,  0, 0, 0, 0, 16'd15,    16'd0,    0, 1);
    send(8'd200, 8'd10, 0, 0, 0, 0, 16'd2240,  16'd0,    0, 0);
    send(8'd200, 8'd10, 0, 1, 0, 0, 16'd2000,  16'd0,    0, 0);
    send(8'hFB,  8'h03, 1, 0, 0, 0, 16'hFFF3,  16'd0,    0, 0);
    send(8'hFB,  8'hFD, 1, 0, 0, 0, 16'd8,     16'd0,    0, 0);
    send(8'h00,  8'h37, 0, 0, 0, 0, 16'd0,     16'd0,    0, 0);
    send(8'h00,  8'hFF, 1, 0, 0, 0, 16'hFFFF,  16'd0,    0, 0);
    send(8'h80,  8'h80, 1, 1, 0, 0, 16'h3F01,  16'd0,    0, 0);
    send(8'h80,  8'h80, 1, 0, 0, 0, 16'h3100,  16'd0,    0, 0);
    send(8'd5,   8'd3,  0, 0, 1, 1, 16'd15,    16'd15,   0, 1);
    send(8'd5,   8'd3,  0, 0, 1, 0, 16'd15,    16'd30,   0, 0);
    send(8'd2,   8'd2,  0, 0, 1, 0, 16'd4,     16'd34,   0, 0);
    send(8'd3,   8'd3,  0, 0, 0, 1, 16'd9,     16'd34,   0, 0);
    drain();

    fork
      begin
        send(8'd1, 8'd1, 0, 0, 1, 0, 16'd1,  16'd35,  0, 0);
        send(8'd2, 8'd3, 0, 0, 1, 0, 16'd6,  16'd41,  0, 0);
        send(8'd4, 8'd4, 0, 0, 1, 0, 16'd16, 16'd57,  0, 0);
        send(8'd7, 8'd7, 0, 0, 1, 0, 16'd49, 16'd106, 0, 0);
        send(8'd6, 8'd5, 0, 0, 1, 0, 16'd30, 16'd136, 0, 0);
        send(8'd3, 8'd2, 0, 0, 1, 0, 16'd6,  16'd142, 0, 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall_in_ready",  32'(in_ready),  32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    // Signed accumulate: 0xFFF3 sign-extends to -13
    send(8'hFB, 8'h03, 1, 0, 1, 0, 16'hFFF3, 16'd129, 0, 0);
    drain();

    send(8'h7F, 8'h7F, 1, 0, 1, 1, 16'h3100, 16'h3100, 0, 0);
    send(8'h7F, 8'h7F, 1, 0, 1, 0, 16'h3100, 16'h6200, 0, 0);
    send(8'h7F, 8'h7F, 1, 0, 1, 0, 16'h3100, 16'h9300, 1, 0);
    send(8'h7F, 8'h7F, 1, 0, 1, 0, 16'h3100, 16'hC400, 1, 0);
    send(8'd5,  8'd3,  0, 0, 1, 1, 16'd15,   16'd15,   1, 0);
    send(8'd2,  8'd2,  0, 0, 0, 0, 16'd4,    16'd15,   1, 0);
    drain();

    send(8'd1, 8'd1, 0, 0, 0, 0, 16'd1, 16'd15, 1, 0);
    send(8'd2, 8'd2, 0, 0, 0, 0, 16'd4, 16'd15, 1, 0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_acc",   32'(out_acc),   32'd0);
    chk("midrst_out_ovf",   32'(out_ovf),   32'd0);
    chk("midrst_out_prod",  32'(out_prod),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flushed_out_valid_1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("flushed_out_valid_2", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send(8'd3, 8'd3, 0, 0, 1, 0, 16'd9, 16'd9, 0, 0);
    drain();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
